// File: rtl/e15_core_param_if.sv
// e15_core_param_if: fetch, observation and debug signals of the E15 core.
// master = program source / observer, slave = core.
interface e15_core_param_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int PC_W   = 8
);
    localparam int RSEL_W = $clog2(NREG);
    localparam int IW     = 4 + 2*RSEL_W + DATA_W;

    logic              instr_valid;
    logic [IW-1:0]     instr;
    logic [PC_W-1:0]   pc;
    logic              halted;
    logic              reg_we;
    logic [DATA_W-1:0] dst_bus;
    logic              flag_z;
    logic              flag_c;
    logic [RSEL_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr_valid, instr, dbg_sel,
        input  pc, halted, reg_we, dst_bus, flag_z, flag_c, dbg_data
    );

    modport slave (
        input  instr_valid, instr, dbg_sel,
        output pc, halted, reg_we, dst_bus, flag_z, flag_c, dbg_data
    );
endinterface

// File: rtl/e15_core_param.sv
// e15_core_param: parametrised single-cycle E15 core with external fetch,
// Z/C flags, conditional branches, HALT and a debug register-read port.
// Optional macro E15_SELF_LOOP_HALT_EN: a taken jump to its own pc halts.
module e15_core_param #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int PC_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    e15_core_param_if.slave bus
);
    localparam int RSEL_W = $clog2(NREG);
    localparam int IW     = 4 + 2*RSEL_W + DATA_W;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t            r_state;
    logic              r_halted;
    logic [PC_W-1:0]   r_pc;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [3:0]        w_op;
    logic [RSEL_W-1:0] w_dst;
    logic [RSEL_W-1:0] w_src;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_d;
    logic [DATA_W-1:0] w_s;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_cout;
    logic              w_wr;
    logic              w_fupd;
    logic              w_jtake;
    logic              w_exec;
    logic              w_self;
    logic              w_halt;
    logic [PC_W-1:0]   w_target;

    // Field split: {opcode, dst, src, imm}, MSB first.
    assign w_op     = bus.instr[IW-1 -: 4];
    assign w_dst    = bus.instr[IW-5 -: RSEL_W];
    assign w_src    = bus.instr[IW-5-RSEL_W -: RSEL_W];
    assign w_imm    = bus.instr[DATA_W-1:0];
    assign w_d      = r_regs[w_dst];
    assign w_s      = r_regs[w_src];
    // Size cast truncates or zero-extends the immediate to the pc width.
    assign w_target = PC_W'(w_imm);

    // One extra bit on both adders captures carry-out / borrow.
    assign w_sum  = {1'b0, w_d} + {1'b0, (w_op == 4'd3) ? w_imm : w_s};
    assign w_diff = {1'b0, w_d} - {1'b0, w_s};

    // Decode: result, carry, write/flag enables and branch decision.
    always_comb begin
        w_res   = '0;
        w_cout  = 1'b0;
        w_wr    = 1'b0;
        w_fupd  = 1'b0;
        w_jtake = 1'b0;
        case (w_op)
            4'd0:  begin w_res = w_s;   w_wr = 1'b1; end
            4'd1:  begin w_res = w_imm; w_wr = 1'b1; end
            4'd2, 4'd3: begin
                w_res = w_sum[DATA_W-1:0]; w_cout = w_sum[DATA_W];
                w_wr = 1'b1; w_fupd = 1'b1;
            end
            4'd4: begin
                w_res = w_diff[DATA_W-1:0]; w_cout = w_diff[DATA_W];
                w_wr = 1'b1; w_fupd = 1'b1;
            end
            4'd5:  begin w_res = w_d & w_s; w_wr = 1'b1; w_fupd = 1'b1; end
            4'd6:  begin w_res = w_d | w_s; w_wr = 1'b1; w_fupd = 1'b1; end
            4'd7:  begin w_res = w_d ^ w_s; w_wr = 1'b1; w_fupd = 1'b1; end
            4'd8:  begin w_res = ~w_s;      w_wr = 1'b1; w_fupd = 1'b1; end
            4'd9: begin
                w_res = {w_d[DATA_W-2:0], 1'b0}; w_cout = w_d[DATA_W-1];
                w_wr = 1'b1; w_fupd = 1'b1;
            end
            4'd10: begin
                w_res = {1'b0, w_d[DATA_W-1:1]}; w_cout = w_d[0];
                w_wr = 1'b1; w_fupd = 1'b1;
            end
            4'd11: w_jtake = 1'b1;
            4'd12: w_jtake = r_z;
            4'd13: w_jtake = ~r_z;
            4'd14: w_jtake = r_c;
            default: ;
        endcase
    end

    assign w_exec = (r_state == S_RUN) && bus.instr_valid;

`ifdef E15_SELF_LOOP_HALT_EN
    assign w_self = w_jtake && (w_target == r_pc);
`else
    assign w_self = 1'b0;
`endif

    assign w_halt = w_exec && ((w_op == 4'd15) || w_self);

    // Core state: run/halt FSM, pc, flags and register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_pc     <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
        end else if (w_exec) begin
            if (w_halt) begin
                // pc stays on the halting instruction.
                r_state  <= S_HALT;
                r_halted <= 1'b1;
            end else begin
                if (w_wr) r_regs[w_dst] <= w_res;
                if (w_fupd) begin
                    r_z <= (w_res == '0);
                    r_c <= w_cout;
                end
                r_pc <= w_jtake ? w_target : r_pc + PC_W'(1);
            end
        end
    end

    assign bus.pc       = r_pc;
    assign bus.halted   = r_halted;
    assign bus.flag_z   = r_z;
    assign bus.flag_c   = r_c;
    assign bus.reg_we   = w_exec && w_wr;
    assign bus.dst_bus  = (w_exec && w_wr) ? w_res : '0;
    assign bus.dbg_data = r_regs[bus.dbg_sel];
endmodule

// File: tb/tb_e15_core_param.sv
// tb_e15_core_param: directed program sequences for e15_core_param with
// hand-computed register, flag and pc expectations.
module tb_e15_core_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    e15_core_param_if #(.DATA_W(8), .NREG(4), .PC_W(8)) bus ();

    e15_core_param #(.DATA_W(8), .NREG(4), .PC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] d,
                                        input logic [1:0] s, input logic [7:0] i);
        return {op, d, s, i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkreg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        bus.dbg_sel = sel;
        #1;
        chk(tag, 32'(bus.dbg_data), 32'(exp));
    endtask

    // Present one instruction for one edge, sample 1 time unit after it.
    task automatic step(input logic [15:0] ins);
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.dbg_sel     = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_z", 32'(bus.flag_z), 0);
        chk("rst_c", 32'(bus.flag_c), 0);
        chkreg("rst_r0", 2'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic program
        step(enc(4'd1, 2'd0, 2'd0, 8'd5));
        step(enc(4'd1, 2'd1, 2'd0, 8'd3));
        @(negedge clk);
        bus.instr = enc(4'd2, 2'd0, 2'd1, 8'd0);
        bus.instr_valid = 1'b1;
        #1;
        chk("add_reg_we", 32'(bus.reg_we), 1);
        chk("add_dst_bus", 32'(bus.dst_bus), 8);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        step(enc(4'd15, 2'd0, 2'd0, 8'd0));
        chkreg("basic_r0", 2'd0, 8'd8);
        chkreg("basic_r1", 2'd1, 8'd3);
        chk("basic_z", 32'(bus.flag_z), 0);
        chk("basic_c", 32'(bus.flag_c), 0);
        chk("basic_halted", 32'(bus.halted), 1);
        chk("basic_pc", 32'(bus.pc), 3);
        // HALT ignores further instructions
        step(enc(4'd1, 2'd0, 2'd0, 8'd0));
        chkreg("halt_r0_kept", 2'd0, 8'd8);
        chk("halt_pc_kept", 32'(bus.pc), 3);
        chk("halt_reg_we", 32'(bus.reg_we), 0);

        // Carry / wrap / borrow / JC
        do_reset();
        chk("rst2_halted", 32'(bus.halted), 0);
        step(enc(4'd1, 2'd2, 2'd0, 8'd200));
        step(enc(4'd3, 2'd2, 2'd0, 8'd100));
        chkreg("addi_r2", 2'd2, 8'd44);
        chk("addi_c", 32'(bus.flag_c), 1);
        chk("addi_z", 32'(bus.flag_z), 0);
        step(enc(4'd4, 2'd3, 2'd2, 8'd0));
        chkreg("sub_r3", 2'd3, 8'd212);
        chk("sub_c", 32'(bus.flag_c), 1);
        step(enc(4'd14, 2'd0, 2'd0, 8'h20));
        chk("jc_pc", 32'(bus.pc), 32'h20);
        step(enc(4'd0, 2'd0, 2'd3, 8'd0));
        chkreg("mov_r0", 2'd0, 8'd212);
        chk("mov_c_kept", 32'(bus.flag_c), 1);

        // Shifts and logic ops
        step(enc(4'd1, 2'd1, 2'd0, 8'h81));
        step(enc(4'd9, 2'd1, 2'd0, 8'd0));
        chkreg("shl_r1", 2'd1, 8'h02);
        chk("shl_c", 32'(bus.flag_c), 1);
        step(enc(4'd10, 2'd1, 2'd0, 8'd0));
        chkreg("shr_r1", 2'd1, 8'h01);
        chk("shr_c0", 32'(bus.flag_c), 0);
        step(enc(4'd10, 2'd1, 2'd0, 8'd0));
        chk("shr_c1", 32'(bus.flag_c), 1);
        chk("shr_z", 32'(bus.flag_z), 1);
        step(enc(4'd8, 2'd2, 2'd1, 8'd0));
        chkreg("not_r2", 2'd2, 8'hFF);
        chk("not_c", 32'(bus.flag_c), 0);
        chk("not_z", 32'(bus.flag_z), 0);
        step(enc(4'd7, 2'd2, 2'd2, 8'd0));
        chkreg("xor_r2", 2'd2, 8'h00);
        chk("xor_z", 32'(bus.flag_z), 1);
        step(enc(4'd1, 2'd0, 2'd0, 8'h3C));
        step(enc(4'd1, 2'd1, 2'd0, 8'h0F));
        step(enc(4'd5, 2'd0, 2'd1, 8'd0));
        chkreg("and_r0", 2'd0, 8'h0C);
        step(enc(4'd6, 2'd0, 2'd1, 8'd0));
        chkreg("or_r0", 2'd0, 8'h0F);
        step(enc(4'd2, 2'd0, 2'd0, 8'd0));
        chkreg("add_self_r0", 2'd0, 8'h1E);

        // Branching
        do_reset();
        step(enc(4'd1, 2'd0, 2'd0, 8'd1));
        chk("br_pc1", 32'(bus.pc), 1);
        step(enc(4'd4, 2'd0, 2'd0, 8'd0));
        chk("br_pc2", 32'(bus.pc), 2);
        chk("br_z", 32'(bus.flag_z), 1);
        chk("br_c", 32'(bus.flag_c), 0);
        step(enc(4'd12, 2'd0, 2'd0, 8'd6));
        chk("jz_pc", 32'(bus.pc), 6);
        step(enc(4'd13, 2'd0, 2'd0, 8'd0));
        chk("jnz_pc", 32'(bus.pc), 7);

        // Stall
        do_reset();
        step(enc(4'd1, 2'd0, 2'd0, 8'd5));
        @(negedge clk);
        bus.instr = enc(4'd2, 2'd0, 2'd1, 8'd0);
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_reg_we", 32'(bus.reg_we), 0);
        end
        chk("stall_pc", 32'(bus.pc), 1);
        chk("stall_dst_bus", 32'(bus.dst_bus), 0);
        chkreg("stall_r0", 2'd0, 8'd5);
        step(enc(4'd1, 2'd1, 2'd0, 8'd3));
        step(enc(4'd2, 2'd0, 2'd1, 8'd0));
        step(enc(4'd15, 2'd0, 2'd0, 8'd0));
        chkreg("stall_res_r0", 2'd0, 8'd8);
        chk("stall_res_pc", 32'(bus.pc), 3);
        chk("stall_res_halted", 32'(bus.halted), 1);

        // Async reset mid-run
        do_reset();
        step(enc(4'd1, 2'd1, 2'd0, 8'd9));
        step(enc(4'd1, 2'd0, 2'd0, 8'd255));
        step(enc(4'd3, 2'd0, 2'd0, 8'd1));
        step(enc(4'd1, 2'd2, 2'd0, 8'd1));
        chk("pre_ar_pc", 32'(bus.pc), 4);
        chk("pre_ar_z", 32'(bus.flag_z), 1);
        chk("pre_ar_c", 32'(bus.flag_c), 1);
        chkreg("pre_ar_r1", 2'd1, 8'd9);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pc", 32'(bus.pc), 0);
        chk("ar_z", 32'(bus.flag_z), 0);
        chk("ar_c", 32'(bus.flag_c), 0);
        chk("ar_halted", 32'(bus.halted), 0);
        chkreg("ar_r1", 2'd1, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Self-loop jump
        for (int k = 0; k < 50; k++) step(enc(4'd11, 2'd0, 2'd0, 8'd0));
        chk("self_pc", 32'(bus.pc), 0);
`ifdef E15_SELF_LOOP_HALT_EN
        chk("self_halted", 32'(bus.halted), 1);
`else
        chk("self_halted", 32'(bus.halted), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
